// File: rtl/read_ctrl_if.sv
// read_ctrl_if: read-side bus of the asynchronous FIFO read controller.
// Carries the cross-domain pointers, the dual-port memory read port and the
// valid/ready output stream. aw = $clog2(fifo_depth).
interface read_ctrl_if #(
    parameter int aw         = 4,
    parameter int data_width = 8
);
    logic [aw:0]           writeaddrptrgrey;
    logic [aw:0]           readaddrptrgrey;
    logic [aw-1:0]         readaddr;
    logic                  ren_mem;
    logic [data_width-1:0] rdata_mem;
    logic [data_width-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic                  empty;
    logic                  almost_empty;
    logic [aw:0]           rcount;

    // Controller side
    modport master (
        input  writeaddrptrgrey, rdata_mem, dout_ready,
        output readaddrptrgrey, readaddr, ren_mem, dout, dout_valid,
               empty, almost_empty, rcount
    );

    // Environment side: write domain, memory and consumer
    modport slave (
        output writeaddrptrgrey, rdata_mem, dout_ready,
        input  readaddrptrgrey, readaddr, ren_mem, dout, dout_valid,
               empty, almost_empty, rcount
    );
endinterface

// File: rtl/read_ctrl.sv
// read_ctrl: read-domain controller of the asynchronous FIFO.
// Synchronizes the write-side Gray pointer into rclk, derives empty/rcount,
// issues memory reads and presents words on a 2-entry valid/ready buffer.
// Optional feature: define READ_CTRL_SYNC3_EN for a 3-flop synchronizer
// (default is 2 flops; everything else is unchanged).
module read_ctrl #(
    parameter int fifo_depth          = 16,
    parameter int data_width          = 8,
    parameter int almost_empty_thresh = 2
) (
    input  logic         rclk,
    input  logic         rrst,
    read_ctrl_if.master  bus
);
    localparam int aw = $clog2(fifo_depth);

`ifdef READ_CTRL_SYNC3_EN
    localparam int sync_stages = 3;
`else
    localparam int sync_stages = 2;
`endif

    localparam logic [aw:0] ae_thresh = (aw+1)'(almost_empty_thresh);

    logic [aw:0]           sync_q [sync_stages];
    logic [aw:0]           wsync_grey;
    logic [aw:0]           wsync_bin;
    logic [aw:0]           rbin;
    logic [aw:0]           rbin_next;
    logic [aw:0]           rgrey;
    logic [aw:0]           rcount;
    logic                  empty;
    logic                  ren;
    logic                  pop;
    logic [1:0]            obuf_cnt;
    logic                  head_valid;
    logic                  skid_valid;
    logic [data_width-1:0] head_data;
    logic [data_width-1:0] skid_data;

    // Bring the write pointer into rclk through a plain flop chain.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, forming a true shift chain.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            for (int i = 0; i < sync_stages; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= bus.writeaddrptrgrey;
            for (int i = 1; i < sync_stages; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign wsync_grey = sync_q[sync_stages-1];

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    // NOTE: the whole vector gets a default first, so no path leaves a bit
    // unassigned and no latch can be inferred.
    always_comb begin
        wsync_bin = '0;
        for (int i = 0; i <= aw; i++) wsync_bin[i] = ^(wsync_grey >> i);
    end

    // Status and read issue. Comparing against the registered Gray pointer
    // keeps empty pessimistic: a stale write pointer can only hide data.
    assign empty     = (rgrey == wsync_grey);
    assign rcount    = wsync_bin - rbin;
    assign obuf_cnt  = {1'b0, head_valid} + {1'b0, skid_valid};
    assign pop       = head_valid & bus.dout_ready;
    assign ren       = !empty && ((obuf_cnt - {1'b0, pop}) < 2'd2);
    assign rbin_next = rbin + {{aw{1'b0}}, ren};

    // Read pointer in binary and Gray; the Gray copy is registered so the
    // write domain never sees combinational glitches.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin  <= '0;
            rgrey <= '0;
        end else begin
            rbin  <= rbin_next;
            rgrey <= (rbin_next >> 1) ^ rbin_next;
        end
    end

    // Two-entry output buffer: returning words fill head first, skid second;
    // a pop with skid occupied promotes skid to head.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            head_data  <= '0;
            skid_data  <= '0;
        end else if (pop) begin
            if (skid_valid) begin
                head_data  <= skid_data;
                head_valid <= 1'b1;
                skid_valid <= ren;
                if (ren) skid_data <= bus.rdata_mem;
            end else begin
                head_valid <= ren;
                if (ren) head_data <= bus.rdata_mem;
            end
        end else if (ren) begin
            if (!head_valid) begin
                head_valid <= 1'b1;
                head_data  <= bus.rdata_mem;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= bus.rdata_mem;
            end
        end
    end

    assign bus.readaddrptrgrey = rgrey;
    assign bus.readaddr        = rbin[aw-1:0];
    assign bus.ren_mem         = ren;
    assign bus.dout            = head_data;
    assign bus.dout_valid      = head_valid;
    assign bus.empty           = empty;
    assign bus.almost_empty    = (rcount <= ae_thresh);
    assign bus.rcount          = rcount;

endmodule

// File: tb/tb_read_ctrl.sv
// tb_read_ctrl: directed bench for read_ctrl. The bench plays the write domain
// (memory contents plus write pointer) and the consumer; the memory is read
// asynchronously so a word addressed under ren_mem is captured on the next edge.
module tb_read_ctrl;
    localparam int depth = 16;
    localparam int dw    = 8;
    localparam int aw    = 4;

    logic rclk = 1'b0;
    logic rrst;

    read_ctrl_if #(.aw(aw), .data_width(dw)) bus ();

    read_ctrl #(
        .fifo_depth(depth),
        .data_width(dw),
        .almost_empty_thresh(2)
    ) dut (
        .rclk(rclk),
        .rrst(rrst),
        .bus(bus)
    );

    always #5 rclk = ~rclk;

    logic [dw-1:0] mem [depth];
    assign bus.rdata_mem = mem[bus.readaddr];

    int          vectors     = 0;
    int          miscompares = 0;
    logic [aw:0] wbin;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [aw:0] to_grey(input logic [aw:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic set_wptr(input logic [aw:0] b);
        wbin = b;
        bus.writeaddrptrgrey = to_grey(b);
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        rrst = 1'b1;
        bus.dout_ready = 1'b0;
        set_wptr('0);
        tick();
        tick();
        rrst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int reads, exp, first, last, got, total, toggles;
        logic wrapped;
        logic [aw-1:0] prev_addr;
        logic prev_msb;

        for (int i = 0; i < depth; i++) mem[i] = dw'(i * 7 + 3);
        rrst = 1'b1;
        bus.dout_ready = 1'b0;
        set_wptr('0);

        // ---- Reset state
        do_reset();
        check("rst_rgrey",  bus.readaddrptrgrey, 0);
        check("rst_raddr",  bus.readaddr, 0);
        check("rst_ren",    bus.ren_mem, 0);
        check("rst_dout",   bus.dout, 0);
        check("rst_valid",  bus.dout_valid, 0);
        check("rst_empty",  bus.empty, 1);
        check("rst_aempty", bus.almost_empty, 1);
        check("rst_rcount", bus.rcount, 0);

        // ---- Single word: empty falls after 2 edges, data after 3
        set_wptr(5'd1);
        tick();
        check("sw_e1_empty", bus.empty, 1);
        check("sw_e1_ren",   bus.ren_mem, 0);
        tick();
        check("sw_e2_empty",  bus.empty, 0);
        check("sw_e2_ren",    bus.ren_mem, 1);
        check("sw_e2_raddr",  bus.readaddr, 0);
        check("sw_e2_rcount", bus.rcount, 1);
        check("sw_e2_aempty", bus.almost_empty, 1);
        tick();
        check("sw_e3_valid", bus.dout_valid, 1);
        check("sw_e3_dout",  bus.dout, mem[0]);
        check("sw_e3_rgrey", bus.readaddrptrgrey, 1);
        check("sw_e3_empty", bus.empty, 1);
        check("sw_e3_ren",   bus.ren_mem, 0);
        bus.dout_ready = 1'b1;
        tick();
        check("sw_popped_valid", bus.dout_valid, 0);
        bus.dout_ready = 1'b0;

        // ---- Backpressure: 5 words available, consumer stalled
        do_reset();
        set_wptr(5'd5);
        reads = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.ren_mem) reads++;
            tick();
        end
        check("bp_reads",  reads, 2);
        check("bp_ren",    bus.ren_mem, 0);
        check("bp_valid",  bus.dout_valid, 1);
        check("bp_dout",   bus.dout, mem[0]);
        check("bp_rcount", bus.rcount, 3);
        check("bp_aempty", bus.almost_empty, 0);
        bus.dout_ready = 1'b1;
        exp = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.dout_valid) begin
                check("bp_drain_dout", bus.dout, mem[exp % depth]);
                exp++;
            end
            tick();
        end
        check("bp_drain_count", exp, 5);
        check("bp_drain_empty", bus.empty, 1);
        bus.dout_ready = 1'b0;

        // ---- Streaming: 16 words, one per cycle
        do_reset();
        bus.dout_ready = 1'b1;
        set_wptr(5'd16);
        tick();
        tick();
        check("st_empty",  bus.empty, 0);
        check("st_rcount", bus.rcount, 16);
        check("st_aempty", bus.almost_empty, 0);
        check("st_ren",    bus.ren_mem, 1);
        exp = 0;
        first = -1;
        last = -1;
        for (int i = 0; i < 30; i++) begin
            if (bus.dout_valid) begin
                check("st_dout", bus.dout, mem[exp % depth]);
                exp++;
                if (first < 0) first = i;
                last = i;
            end
            tick();
        end
        check("st_count",  exp, 16);
        check("st_span",   last - first + 1, 16);
        check("st_done_empty",  bus.empty, 1);
        check("st_done_rcount", bus.rcount, 0);
        check("st_done_rgrey",  bus.readaddrptrgrey, to_grey(5'd16));

        // ---- Wrap: 40 more words in bursts of 8
        total = 0;
        toggles = 0;
        wrapped = 1'b0;
        prev_addr = bus.readaddr;
        prev_msb = bus.readaddrptrgrey[aw];
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < 8; k++) mem[(int'(wbin) + k) % depth] = dw'(8'h80 + b * 8 + k);
            set_wptr(wbin + 5'd8);
            tick();
            tick();
            check("wr_rcount", bus.rcount, 8);
            got = 0;
            for (int i = 0; i < 20 && got < 8; i++) begin
                if (bus.dout_valid) begin
                    check("wr_dout", bus.dout, dw'(8'h80 + total));
                    total++;
                    got++;
                end
                tick();
                if (prev_addr == 4'd15 && bus.readaddr == 4'd0) wrapped = 1'b1;
                if (bus.readaddrptrgrey[aw] != prev_msb) toggles++;
                prev_addr = bus.readaddr;
                prev_msb = bus.readaddrptrgrey[aw];
            end
            check("wr_burst_count", got, 8);
        end
        tick();
        check("wr_total",   total, 40);
        check("wr_wrapped", wrapped, 1);
        check("wr_toggles", toggles, 2);
        check("wr_rgrey",   bus.readaddrptrgrey, to_grey(5'd24));
        check("wr_empty",   bus.empty, 1);
        check("wr_rcount",  bus.rcount, 0);
        check("wr_valid",   bus.dout_valid, 0);

        // ---- Reset mid-stream with both buffer entries occupied
        do_reset();
        set_wptr(5'd5);
        for (int i = 0; i < 6; i++) tick();
        check("mr_pre_valid", bus.dout_valid, 1);
        check("mr_pre_raddr", bus.readaddr, 2);
        #3;
        rrst = 1'b1;
        #1;
        check("mr_valid",  bus.dout_valid, 0);
        check("mr_dout",   bus.dout, 0);
        check("mr_raddr",  bus.readaddr, 0);
        check("mr_rgrey",  bus.readaddrptrgrey, 0);
        check("mr_empty",  bus.empty, 1);
        check("mr_rcount", bus.rcount, 0);
        check("mr_ren",    bus.ren_mem, 0);
        set_wptr('0);
        tick();
        rrst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mr_post_empty", bus.empty, 1);
        check("mr_post_valid", bus.dout_valid, 0);
        check("mr_post_ren",   bus.ren_mem, 0);
        check("mr_post_rcount", bus.rcount, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/read_ctrl.md
# read_ctrl

Read-domain controller of the asynchronous FIFO; the mirror stage of the write-pointer block. Synchronizes the incoming write-side Gray pointer into `rclk`, derives `empty`/occupancy, drives the dual-port memory read port, and presents data on a 2-entry valid/ready output buffer at full throughput. Its registered Gray read pointer is the value the write side synchronizes for its `full` flag.

## Interface
AW = $clog2(fifo_depth).

Parameters:
- fifo_depth, 16, FIFO entries; power of two, ≥4
- data_width, 8, word width
- almost_empty_thresh, 2, `almost_empty` asserts when rcount ≤ this value

Ports:
- rclk  in  1  read clock; single clock domain, all logic on rising edge
- rrst  in  1  reset, asynchronous, active-high
- writeaddrptrgrey  in  AW+1  write pointer, Gray, from `wclk` domain, unsynchronized
- readaddrptrgrey  out  AW+1  read pointer, Gray, registered, to write-side synchronizer
- readaddr  out  AW  memory read address = read binary pointer [AW-1:0]
- ren_mem  out  1  memory read strobe
- rdata_mem  in  data_width  memory data, valid on the `rclk` edge after `ren_mem`
- dout  out  data_width  head-of-queue data
- dout_valid  out  1  `dout` holds a valid word
- dout_ready  in  1  consumer accepts `dout` when high with `dout_valid`
- empty  out  1  no unread entries in memory (synced view)
- almost_empty  out  1  rcount ≤ almost_empty_thresh
- rcount  out  AW+1  entries in memory not yet read (synced view), 0..fifo_depth

## Operation
- Synchronizer: 2-flop chain on `writeaddrptrgrey` → wsync_grey; wsync_bin = Gray-to-binary(wsync_grey).
- Read pointer rbin (AW+1 bits) increments by 1 on each cycle `ren_mem`=1; wraps 2^(AW+1)-1 → 0. readaddrptrgrey = registered (rbin_next>>1)^rbin_next; never combinational.
- empty = (readaddrptrgrey == wsync_grey). rcount = wsync_bin − rbin, modulo 2^(AW+1).
- Output buffer: credit counter obuf_cnt ∈ {0,1,2} = words held + reads in flight. pop = dout_valid & dout_ready.
- ren_mem = !empty & (obuf_cnt − pop < 2); never asserted while empty.
- Buffer entries: head (drives `dout`) and skid. Returning word goes to head if head is empty or popped this cycle, else to skid. On pop with skid full, skid moves to head.
- Order strictly FIFO; no word duplicated or dropped.
- Simultaneous pop and returning read: both occur same edge; obuf_cnt unchanged.

## Timing
- Reset values: readaddrptrgrey=0, readaddr=0, ren_mem=0, dout=0, dout_valid=0, empty=1, almost_empty=1, rcount=0, sync flops=0, obuf_cnt=0.
- Reset is asynchronous at assertion; mid-operation reset discards buffered and in-flight words immediately.
- Write pointer change → `empty` falls after 2 `rclk` edges; `ren_mem` high in that same cycle.
- `ren_mem` at edge N → data captured at edge N+1 → `dout_valid` high after edge N+1.
- End-to-end: write pointer change to `dout_valid` = 3 `rclk` edges.
- Sustained throughput: one word per cycle with `dout_ready` held high.
- `dout`/`dout_valid` stable while `dout_valid`=1 and `dout_ready`=0.
- `rcount` and `empty` are pessimistic (stale write pointer); never overstate available data.

## Configuration
- READ_CTRL_SYNC3_EN defined: 3-flop synchronizer; empty-deassert latency 3 edges, end-to-end 4.
- Undefined: 2-flop synchronizer as above. All other behaviour identical.

## Test plan
- Reset: rrst pulse mid-clock → all outputs at reset values immediately; empty=1, rcount=0, dout_valid=0.
- Single word: writeaddrptrgrey 0→1 → after 2 edges ren_mem=1, readaddr=0; next edge dout_valid=1, dout=mem[0], readaddrptrgrey=1, empty=1.
- Backpressure: writeaddrptrgrey=7 (bin 5), dout_ready=0 → exactly 2 reads, ren_mem then 0, dout=mem[0] held, rcount=3.
- Streaming: 16 words available, dout_ready=1 → dout_valid high 16 consecutive cycles, mem[0..15] in order, then empty=1.
- Wrap: stream 40 words in bursts of 8 → readaddr wraps 15→0, pointer bit AW toggles, rcount correct throughout, no duplicates.
- Reset mid-stream: rrst with obuf_cnt=2 → dout_valid=0, rbin=0 same cycle; after release and writeaddrptrgrey=0, stays empty.
